ps2_key_decoder: RTL
====================

# ps2_key_decoder

Consumes raw PS/2 set-2 scan codes from the keyboard receiver's FIFO and turns them into key events: make/break flag, extended flag, modifier state and a US-layout ASCII code. It sits directly downstream of the PS/2 keyboard receiver. It pops one byte at a time using the receiver's active-low `nextdata_n` pulse. It presents decoded events to the console or terminal logic over a valid/ready handshake.

## Interface
- No parameters.
- `clk` in 1: system clock, same domain as the receiver.
- `clrn` in 1: asynchronous, active-low reset.
- `kbd_data` in 8: receiver FIFO head byte; valid while `kbd_ready`=1.
- `kbd_ready` in 1: receiver FIFO non-empty.
- `kbd_overflow` in 1: receiver FIFO overflow flag.
- `kbd_nextdata_n` out 1: active-low pop. Exactly one cycle low per byte consumed.
- `ev_valid` out 1: event available.
- `ev_ready` in 1: consumer accepts the event.
- `ev_code` out 8: final scan code, with prefixes stripped.
- `ev_ascii` out 8: ASCII code, or 0x00 if none.
- `ev_break` out 1: 1 = key release.
- `ev_ext` out 1: 1 = E0-prefixed key.
- `shift`, `ctrl`, `caps_lock` out 1 each: current modifier state.
- `err_overflow` out 1: sticky; set when `kbd_overflow`=1 and cleared only by reset.

## Operation
- FSM states are IDLE, POP, DECODE and EMIT. All outputs are registered.
- **IDLE:** if `kbd_ready`=1, latch `kbd_data` into `code_r` and go to POP.
- **POP:** `kbd_nextdata_n`=0 for this single cycle, then go to DECODE.
- **DECODE:**
  - 0xF0: set `brk_pend`; go to IDLE with no event.
  - 0xE0: set `ext_pend`; go to IDLE with no event.
  - Any other byte: load `ev_code`=`code_r`, `ev_break`=`brk_pend`, `ev_ext`=`ext_pend`. Compute `ev_ascii` and update modifiers. Clear both pending flags. Go to EMIT.
- **EMIT:** `ev_valid`=1. Hold all `ev_*` outputs stable until `ev_ready`=1, then go to IDLE. No pop occurs while in EMIT; backpressure propagates into the receiver FIFO.
- **Modifiers:**
  - `shift` = left (0x12) held OR right (0x59) held. Track two internal bits, non-ext only.
  - `ctrl` = 0x14 held, ext or not. Track two bits.
  - Caps (0x58, non-ext) toggles `caps_lock` on make only when `caps_held`=0. `caps_held` is set on make and cleared on break, so typematic repeats do not re-toggle.
- **ASCII:** 0x00 for break, ext, modifier and unmapped codes. Otherwise:
  - Letters a–z: lowercase when `shift` XOR `caps_lock` = 0, uppercase otherwise.
  - Digits 0–9: shifted gives the US symbols `)!@#$%^&*(`.
  - 0x29 → 0x20, 0x5A → 0x0D, 0x66 → 0x08, 0x0D → 0x09, 0x76 → 0x1B.
  - The modifier state used is the value *before* the current event's update.
- Prefixes carry across bytes. E0 F0 xx gives `ev_break`=1, `ev_ext`=1. A repeated prefix leaves its flag set (idempotent).

## Timing
- **Reset values:** `kbd_nextdata_n`=1, `ev_valid`=0, `ev_code`/`ev_ascii`=0x00, `ev_break`/`ev_ext`=0, all modifiers=0, `err_overflow`=0. FSM goes to IDLE and the pending flags clear.
- Reset mid-operation (any state) aborts immediately. A byte already popped is lost.
- **Latency:** if `kbd_ready`=1 at edge N in IDLE:
  - `kbd_nextdata_n` is low for cycle N..N+1.
  - DECODE runs in cycle N+1..N+2.
  - `ev_valid` rises at edge N+2.
- A prefix byte costs 3 cycles with no event.
- **Throughput:** one event per 4 cycles when `ev_ready` is tied high. Handshake completes on the edge where `ev_valid`=`ev_ready`=1, and FSM is in IDLE the next cycle.
- `kbd_ready` is only sampled in IDLE. The receiver's updated `ready`/`data` after the pop edge is first sampled one cycle later, so the same byte is never consumed twice.
- `err_overflow` is set on the first edge where `kbd_overflow`=1, independent of FSM state.

## Structure
- Package `ps2_pkg`: FSM state enum, prefix constants (0xE0, 0xF0), modifier and special-key scan code constants.
- Sub-module `ps2_scan2ascii`: purely combinational table with inputs code, shift, caps and output ascii. Instantiated once in the DECODE path.

## Test plan
- Feed 0x1C, 0xF0, 0x1C with `ev_ready`=1 → two events: (code 0x1C, ascii 0x61, break 0) then (0x1C, 0x00, break 1); exactly three `kbd_nextdata_n` pulses.
- Feed 0x12, 0x1C, 0x16, 0xF0, 0x12, 0x1C → `shift`=1 after the first event; ascii 0x41 then 0x21; then `shift`=0 and ascii 0x61.
- Feed 0x58, 0x58, 0x58, 0xF0, 0x58, then 0x1C → `caps_lock`=1 (toggled once despite repeats); 0x1C gives ascii 0x41.
- Feed 0xE0, 0x75, 0xE0, 0xF0, 0x75 → (0x75, ext 1, break 0, ascii 0x00) then (0x75, ext 1, break 1).
- Queue three codes with `ev_ready`=0 for 20 cycles → `ev_valid` held with stable outputs; `kbd_nextdata_n` stays 1 after the first pop; on release, events arrive in order. Pulse `kbd_overflow` → `err_overflow` stays 1.
- Assert `clrn`=0 during EMIT with `shift`=1 → all outputs return to reset values asynchronously; the next byte decodes unshifted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_DECODE,
        ST_EMIT
    } state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_TAB    = 8'h0D;
    localparam logic [7:0] SC_ESC    = 8'h76;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to US-layout ASCII lookup; 0x00 when unmapped.
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;

    always_comb begin
        letter = '0;
        ascii  = '0;
        case (code)
            8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
            8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
            8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
            8'h45: ascii = shift ? 8'h29 : 8'h30;
            8'h16: ascii = shift ? 8'h21 : 8'h31;
            8'h1E: ascii = shift ? 8'h40 : 8'h32;
            8'h26: ascii = shift ? 8'h23 : 8'h33;
            8'h25: ascii = shift ? 8'h24 : 8'h34;
            8'h2E: ascii = shift ? 8'h25 : 8'h35;
            8'h36: ascii = shift ? 8'h5E : 8'h36;
            8'h3D: ascii = shift ? 8'h26 : 8'h37;
            8'h3E: ascii = shift ? 8'h2A : 8'h38;
            8'h46: ascii = shift ? 8'h28 : 8'h39;
            SC_SPACE: ascii = 8'h20;
            SC_ENTER: ascii = 8'h0D;
            SC_BKSP:  ascii = 8'h08;
            SC_TAB:   ascii = 8'h09;
            SC_ESC:   ascii = 8'h1B;
            default: ;
        endcase
        // Letters are case-folded only after the table lookup so shift and caps cancel.
        if (letter != 8'h00) begin
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops PS/2 set-2 bytes from the receiver FIFO and emits key events with modifier state.
module ps2_key_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic [7:0] ev_ascii,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic       err_overflow
);

    state_e     state_q, state_d;
    logic [7:0] code_q, code_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       ev_valid_q, ev_valid_d;
    logic [7:0] ev_code_q, ev_code_d;
    logic [7:0] ev_ascii_q, ev_ascii_d;
    logic       ev_break_q, ev_break_d;
    logic       ev_ext_q, ev_ext_d;
    logic       brk_pend_q, brk_pend_d;
    logic       ext_pend_q, ext_pend_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d;
    logic       rctrl_q, rctrl_d;
    logic       caps_held_q, caps_held_d;
    logic       caps_lock_q, caps_lock_d;
    logic       err_ovf_q, err_ovf_d;

    logic [7:0] table_ascii;
    logic       is_mod;
    logic       make;

    ps2_scan2ascii u_scan2ascii (
        .code  (code_q),
        .shift (lshift_q | rshift_q),
        .caps  (caps_lock_q),
        .ascii (table_ascii)
    );

    assign make   = ~brk_pend_q;
    assign is_mod = (code_q == SC_CTRL) ||
                    (!ext_pend_q && ((code_q == SC_LSHIFT) || (code_q == SC_RSHIFT) ||
                                     (code_q == SC_CAPS)));

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        nextdata_n_d = 1'b1;
        ev_valid_d   = ev_valid_q;
        ev_code_d    = ev_code_q;
        ev_ascii_d   = ev_ascii_q;
        ev_break_d   = ev_break_q;
        ev_ext_d     = ev_ext_q;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        lctrl_d      = lctrl_q;
        rctrl_d      = rctrl_q;
        caps_held_d  = caps_held_q;
        caps_lock_d  = caps_lock_q;
        err_ovf_d    = err_ovf_q | kbd_overflow;

        case (state_q)
            ST_IDLE: begin
                if (kbd_ready) begin
                    code_d       = kbd_data;
                    nextdata_n_d = 1'b0;
                    state_d      = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (code_q == PFX_BRK) begin
                    brk_pend_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (code_q == PFX_EXT) begin
                    ext_pend_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    ev_code_d  = code_q;
                    ev_break_d = brk_pend_q;
                    ev_ext_d   = ext_pend_q;
                    // Lookup uses modifier flops before this event updates them.
                    ev_ascii_d = (brk_pend_q || ext_pend_q || is_mod) ? 8'h00 : table_ascii;
                    if (!ext_pend_q && code_q == SC_LSHIFT) lshift_d = make;
                    if (!ext_pend_q && code_q == SC_RSHIFT) rshift_d = make;
                    if (code_q == SC_CTRL) begin
                        if (ext_pend_q) rctrl_d = make;
                        else            lctrl_d = make;
                    end
                    if (!ext_pend_q && code_q == SC_CAPS) begin
                        if (make) begin
                            if (!caps_held_q) caps_lock_d = ~caps_lock_q;
                            caps_held_d = 1'b1;
                        end else begin
                            caps_held_d = 1'b0;
                        end
                    end
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                    ev_valid_d = 1'b1;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (ev_ready) begin
                    ev_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            nextdata_n_q <= 1'b1;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= '0;
            ev_ascii_q   <= '0;
            ev_break_q   <= 1'b0;
            ev_ext_q     <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            caps_held_q  <= 1'b0;
            caps_lock_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            nextdata_n_q <= nextdata_n_d;
            ev_valid_q   <= ev_valid_d;
            ev_code_q    <= ev_code_d;
            ev_ascii_q   <= ev_ascii_d;
            ev_break_q   <= ev_break_d;
            ev_ext_q     <= ev_ext_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            lctrl_q      <= lctrl_d;
            rctrl_q      <= rctrl_d;
            caps_held_q  <= caps_held_d;
            caps_lock_q  <= caps_lock_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign kbd_nextdata_n = nextdata_n_q;
    assign ev_valid       = ev_valid_q;
    assign ev_code        = ev_code_q;
    assign ev_ascii       = ev_ascii_q;
    assign ev_break       = ev_break_q;
    assign ev_ext         = ev_ext_q;
    assign shift          = lshift_q | rshift_q;
    assign ctrl           = lctrl_q | rctrl_q;
    assign caps_lock      = caps_lock_q;
    assign err_overflow   = err_ovf_q;

endmodule
